conv_bus_sched: RTL and testbench

Shared serial-bus scheduler for the board's converter chain: two 10-bit DAC channels (A, B) and one 10-bit ADC on a single SCK/SDIN/SDOUT bus with per-device select lines. Requesters post DAC codes or ADC sample requests. The block arbitrates round-robin, serialises one 16-bit frame at a time MSB-first, and returns ADC results with a valid strobe. It replaces free-running per-channel frame generators so higher-level control logic can update outputs and sample on demand.

---
 rtl/conv_bus_sched_if.sv | 33 +++
 rtl/conv_bus_sched.sv | 194 +++++++++++++++++++
 tb/tb_conv_bus_sched.sv | 446 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_bus_sched_if.sv
// Request/ack handshakes and the shared converter serial bus for conv_bus_sched.
// master = requester/board side, slave = the scheduler.
interface conv_bus_sched_if;
  logic       req_a;
  logic       req_b;
  logic       req_ad;
  logic [9:0] code_a;
  logic [9:0] code_b;
  logic       ack_a;
  logic       ack_b;
  logic       ack_ad;
  logic [9:0] ad_data;
  logic       ad_valid;
  logic       busy;
  logic       SCK;
  logic       SDIN;
  logic       SDOUT;
  logic       CSLD_A;
  logic       CSLD_B;
  logic       CS_AD;

  modport master (
    output req_a, req_b, req_ad, code_a, code_b, SDOUT,
    input  ack_a, ack_b, ack_ad, ad_data, ad_valid, busy,
           SCK, SDIN, CSLD_A, CSLD_B, CS_AD
  );

  modport slave (
    input  req_a, req_b, req_ad, code_a, code_b, SDOUT,
    output ack_a, ack_b, ack_ad, ad_data, ad_valid, busy,
           SCK, SDIN, CSLD_A, CSLD_B, CS_AD
  );
endinterface

// File: rtl/conv_bus_sched.sv
// Round-robin scheduler sharing one SCK/SDIN/SDOUT bus between DAC A, DAC B and the ADC.
// One 16-bit MSB-first frame at a time, followed by a CLK_DIV-cycle gap with all selects high.
module conv_bus_sched #(
  parameter int unsigned CLK_DIV  = 8,
  parameter logic [3:0]  DAC_CTRL = 4'b1111,
  parameter logic [15:0] ADC_CMD  = 16'h0000
) (
  input  logic            CLK,
  input  logic            RST,
  conv_bus_sched_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;
  typedef enum logic [1:0] {DEV_A, DEV_B, DEV_AD} dev_t;

  localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);
  localparam logic [7:0] HOLD_LAST = 8'(CLK_DIV - 2);

  state_t      state_q, state_d;
  dev_t        dev_q, dev_d;
  dev_t        last_q, last_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [4:0]  falls_q, falls_d;
  logic [15:0] tx_q, tx_d;
  logic [9:0]  rx_q, rx_d;
  logic        sck_q, sck_d;
  logic        csld_a_q, csld_a_d;
  logic        csld_b_q, csld_b_d;
  logic        cs_ad_q, cs_ad_d;
  logic        ack_a_q, ack_a_d;
  logic        ack_b_q, ack_b_d;
  logic        ack_ad_q, ack_ad_d;
  logic [9:0]  ad_data_q, ad_data_d;
  logic        ad_valid_q, ad_valid_d;
  logic        busy_q, busy_d;

  logic [2:0]  req_vec;
  logic [1:0]  rr_idx;
  logic        found;
  dev_t        pick;
  logic [9:0]  pick_code;

  assign req_vec   = {bus.req_ad, bus.req_b, bus.req_a};
  assign pick_code = (pick == DEV_B) ? bus.code_b : bus.code_a;

  // Search order starts at the requester after the one served last.
  always_comb begin
    found  = 1'b0;
    pick   = DEV_A;
    rr_idx = 2'd0;
    for (int i = 1; i <= 3; i++) begin
      rr_idx = 2'((int'(last_q) + i) % 3);
      if (!found && req_vec[rr_idx]) begin
        found = 1'b1;
        pick  = dev_t'(rr_idx);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    dev_d      = dev_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    falls_d    = falls_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    sck_d      = sck_q;
    csld_a_d   = csld_a_q;
    csld_b_d   = csld_b_q;
    cs_ad_d    = cs_ad_q;
    ack_a_d    = 1'b0;
    ack_b_d    = 1'b0;
    ack_ad_d   = 1'b0;
    ad_data_d  = ad_data_q;
    ad_valid_d = 1'b0;
    busy_d     = busy_q;

    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = SHIFT;
          dev_d   = pick;
          last_d  = pick;
          cnt_d   = '0;
          falls_d = '0;
          rx_d    = '0;
          busy_d  = 1'b1;
          tx_d    = (pick == DEV_AD) ? ADC_CMD : {DAC_CTRL, pick_code, 2'b00};
          unique case (pick)
            DEV_A:   begin ack_a_d  = 1'b1; csld_a_d = 1'b0; end
            DEV_B:   begin ack_b_d  = 1'b1; csld_b_d = 1'b0; end
            default: begin ack_ad_d = 1'b1; cs_ad_d  = 1'b0; end
          endcase
        end
      end

      SHIFT: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
          sck_d = ~sck_q;
          if (!sck_q) begin
            // Rise k samples ADC bit k: bit 0 is the null bit, bits 11..15 are unused.
            if (falls_q != 5'd0 && falls_q <= 5'd10) begin
              rx_d = {rx_q[8:0], bus.SDOUT};
            end
          end else begin
            tx_d    = {tx_q[14:0], 1'b0};
            falls_d = falls_q + 5'd1;
            if (falls_q == 5'd15) begin
              state_d  = HOLD;
              csld_a_d = 1'b1;
              csld_b_d = 1'b1;
              cs_ad_d  = 1'b1;
              if (dev_q == DEV_AD) begin
                ad_data_d  = rx_q;
                ad_valid_d = 1'b1;
              end
            end
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      HOLD: begin
        // Leaving one cycle early lets the next grant land exactly 33*CLK_DIV after the last.
        if (cnt_q == HOLD_LAST) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      dev_q      <= DEV_A;
      last_q     <= DEV_AD;
      cnt_q      <= '0;
      falls_q    <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      sck_q      <= 1'b0;
      csld_a_q   <= 1'b1;
      csld_b_q   <= 1'b1;
      cs_ad_q    <= 1'b1;
      ack_a_q    <= 1'b0;
      ack_b_q    <= 1'b0;
      ack_ad_q   <= 1'b0;
      ad_data_q  <= '0;
      ad_valid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      dev_q      <= dev_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      falls_q    <= falls_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      sck_q      <= sck_d;
      csld_a_q   <= csld_a_d;
      csld_b_q   <= csld_b_d;
      cs_ad_q    <= cs_ad_d;
      ack_a_q    <= ack_a_d;
      ack_b_q    <= ack_b_d;
      ack_ad_q   <= ack_ad_d;
      ad_data_q  <= ad_data_d;
      ad_valid_q <= ad_valid_d;
      busy_q     <= busy_d;
    end
  end

  // SDIN is the transmit MSB; the register drains to zero by the end of every frame.
  assign bus.SDIN     = tx_q[15];
  assign bus.SCK      = sck_q;
  assign bus.CSLD_A   = csld_a_q;
  assign bus.CSLD_B   = csld_b_q;
  assign bus.CS_AD    = cs_ad_q;
  assign bus.ack_a    = ack_a_q;
  assign bus.ack_b    = ack_b_q;
  assign bus.ack_ad   = ack_ad_q;
  assign bus.ad_data  = ad_data_q;
  assign bus.ad_valid = ad_valid_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_conv_bus_sched.sv
// Bench for conv_bus_sched: two instances (CLK_DIV 8 and 2) checked every cycle against a
// frame-timing model, plus directed scenarios pinned with hand-computed literals.
module tb_conv_bus_sched;

  localparam int D0 = 8;
  localparam int D1 = 2;

  typedef struct packed {
    logic       sck;
    logic       sdin;
    logic       csa;
    logic       csb;
    logic       csad;
    logic       acka;
    logic       ackb;
    logic       ackad;
    logic       busy;
    logic       valid;
    logic [9:0] data;
  } obs_t;

  logic clk;
  logic rst;

  logic [2:0] req_v  [2];
  logic [9:0] code_v [2][2];
  logic       sdout_v[2];

  conv_bus_sched_if if0 ();
  conv_bus_sched_if if1 ();

  assign if0.req_a  = req_v[0][0];
  assign if0.req_b  = req_v[0][1];
  assign if0.req_ad = req_v[0][2];
  assign if0.code_a = code_v[0][0];
  assign if0.code_b = code_v[0][1];
  assign if0.SDOUT  = sdout_v[0];
  assign if1.req_a  = req_v[1][0];
  assign if1.req_b  = req_v[1][1];
  assign if1.req_ad = req_v[1][2];
  assign if1.code_a = code_v[1][0];
  assign if1.code_b = code_v[1][1];
  assign if1.SDOUT  = sdout_v[1];

  conv_bus_sched #(.CLK_DIV(D0)) dut0 (.CLK(clk), .RST(rst), .bus(if0));
  conv_bus_sched #(.CLK_DIV(D1)) dut1 (.CLK(clk), .RST(rst), .bus(if1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int div_v [2];

  // Input values the DUT saw at the most recent rising edge
  logic       rst_s;
  logic [2:0] req_s  [2];
  logic [9:0] code_s [2][2];

  // Model state: one frame in flight per instance, described by its grant cycle
  bit          act    [2];
  int          gcyc   [2];
  int          mdev   [2];
  int          mlast  [2];
  logic [15:0] mframe [2];
  logic [15:0] mword  [2];
  logic [9:0]  mdata  [2];
  bit          use_word [2];
  logic [15:0] next_word[2];
  obs_t        exp_o  [2];
  obs_t        obs    [2];

  // Monitors over DUT outputs for the directed scenarios
  int          mon_rises [2];
  logic [15:0] mon_bits  [2];
  int          mon_sel_low [2][3];
  int          mon_ack   [2][3];
  int          mon_valid [2];
  logic [9:0]  mon_vdata [2];
  int          mon_dual  [2];
  int          ack_n     [2];
  int          ack_t     [2][16];
  int          ack_d     [2][16];
  logic        prev_sck  [2];

  task automatic cmp(input string name, input int i, input logic [9:0] got, input logic [9:0] want);
    n_assert++;
    if (got !== want) begin
      n_fail++;
      $display("[TB] FAIL %s inst%0d cycle %0d: got %0h, expected %0h", name, i, cyc, got, want);
    end
  endtask

  task automatic chk(input string name, input int got, input int want);
    n_assert++;
    if (got != want) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, got, got, want, want);
    end
  endtask

  task automatic modelStep(input int i);
    int   d;
    int   t;
    bit   fire;
    int   dev;
    int   idx;
    obs_t e;
    d = div_v[i];
    e = '0;
    e.csa = 1'b1; e.csb = 1'b1; e.csad = 1'b1;
    if (rst_s) begin
      act[i]   = 1'b0;
      mlast[i] = 2;
      mdata[i] = '0;
      e.data   = '0;
      exp_o[i] = e;
      return;
    end
    fire = 1'b0;
    dev  = 0;
    if (!act[i] || cyc >= gcyc[i] + 33 * d) begin
      for (int k = 1; k <= 3; k++) begin
        idx = (mlast[i] + k) % 3;
        if (!fire && req_s[i][idx]) begin
          fire = 1'b1;
          dev  = idx;
        end
      end
      if (fire) begin
        act[i]    = 1'b1;
        gcyc[i]   = cyc;
        mdev[i]   = dev;
        mlast[i]  = dev;
        mframe[i] = (dev == 2) ? 16'h0000 : {4'b1111, code_s[i][dev], 2'b00};
        mword[i]  = use_word[i] ? next_word[i] : 16'($urandom);
        use_word[i] = 1'b0;
      end
    end
    if (act[i]) begin
      t = cyc - gcyc[i];
      if (t < 32 * d) begin
        e.busy = 1'b1;
        e.sck  = ((t / d) % 2) == 1;
        e.sdin = mframe[i][15 - t / (2 * d)];
        case (mdev[i])
          0: begin e.csa  = 1'b0; e.acka  = (t == 0); end
          1: begin e.csb  = 1'b0; e.ackb  = (t == 0); end
          default: begin e.csad = 1'b0; e.ackad = (t == 0); end
        endcase
      end else if (t < 33 * d - 1) begin
        e.busy = 1'b1;
        if (t == 32 * d && mdev[i] == 2) begin
          mdata[i] = mword[i][14:5];
          e.valid  = 1'b1;
        end
      end
    end
    e.data   = mdata[i];
    exp_o[i] = e;
  endtask

  task automatic checkOutput(input int i);
    cmp("SCK",      i, 10'(obs[i].sck),   10'(exp_o[i].sck));
    cmp("SDIN",     i, 10'(obs[i].sdin),  10'(exp_o[i].sdin));
    cmp("CSLD_A",   i, 10'(obs[i].csa),   10'(exp_o[i].csa));
    cmp("CSLD_B",   i, 10'(obs[i].csb),   10'(exp_o[i].csb));
    cmp("CS_AD",    i, 10'(obs[i].csad),  10'(exp_o[i].csad));
    cmp("ack_a",    i, 10'(obs[i].acka),  10'(exp_o[i].acka));
    cmp("ack_b",    i, 10'(obs[i].ackb),  10'(exp_o[i].ackb));
    cmp("ack_ad",   i, 10'(obs[i].ackad), 10'(exp_o[i].ackad));
    cmp("busy",     i, 10'(obs[i].busy),  10'(exp_o[i].busy));
    cmp("ad_valid", i, 10'(obs[i].valid), 10'(exp_o[i].valid));
    cmp("ad_data",  i, obs[i].data,       exp_o[i].data);
  endtask

  task automatic driveSdout(input int i);
    int t1;
    int d;
    d = div_v[i];
    sdout_v[i] = 1'($urandom);
    if (act[i] && mdev[i] == 2) begin
      t1 = cyc + 1 - gcyc[i];
      if (t1 >= 0 && t1 < 32 * d) sdout_v[i] = mword[i][15 - t1 / (2 * d)];
    end
  endtask

  task automatic updateMon(input int i);
    int lows;
    if (obs[i].sck && !prev_sck[i]) begin
      mon_rises[i]++;
      mon_bits[i] = {mon_bits[i][14:0], obs[i].sdin};
    end
    prev_sck[i] = obs[i].sck;
    lows = 0;
    if (!obs[i].csa)  begin mon_sel_low[i][0]++; lows++; end
    if (!obs[i].csb)  begin mon_sel_low[i][1]++; lows++; end
    if (!obs[i].csad) begin mon_sel_low[i][2]++; lows++; end
    if (lows > 1) mon_dual[i]++;
    for (int j = 0; j < 3; j++) begin
      if ((j == 0 && obs[i].acka) || (j == 1 && obs[i].ackb) || (j == 2 && obs[i].ackad)) begin
        mon_ack[i][j]++;
        if (ack_n[i] < 16) begin
          ack_t[i][ack_n[i]] = cyc;
          ack_d[i][ack_n[i]] = j;
        end
        ack_n[i]++;
      end
    end
    if (obs[i].valid) begin
      mon_valid[i]++;
      mon_vdata[i] = obs[i].data;
    end
  endtask

  task automatic clearMon(input int i);
    mon_rises[i] = 0;
    mon_bits[i]  = '0;
    mon_valid[i] = 0;
    mon_vdata[i] = '0;
    mon_dual[i]  = 0;
    ack_n[i]     = 0;
    for (int j = 0; j < 3; j++) begin
      mon_sel_low[i][j] = 0;
      mon_ack[i][j]     = 0;
    end
    for (int k = 0; k < 16; k++) begin
      ack_t[i][k] = -1;
      ack_d[i][k] = -1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    rst_s = rst;
    for (int i = 0; i < 2; i++) begin
      req_s[i]     = req_v[i];
      code_s[i][0] = code_v[i][0];
      code_s[i][1] = code_v[i][1];
    end
    @(negedge clk);
    cyc++;
    obs[0] = {if0.SCK, if0.SDIN, if0.CSLD_A, if0.CSLD_B, if0.CS_AD, if0.ack_a, if0.ack_b,
              if0.ack_ad, if0.busy, if0.ad_valid, if0.ad_data};
    obs[1] = {if1.SCK, if1.SDIN, if1.CSLD_A, if1.CSLD_B, if1.CS_AD, if1.ack_a, if1.ack_b,
              if1.ack_ad, if1.busy, if1.ad_valid, if1.ad_data};
    for (int i = 0; i < 2; i++) begin
      modelStep(i);
      checkOutput(i);
      updateMon(i);
      driveSdout(i);
    end
  endtask

  task automatic waitAck(input int i, input int j, input int limit, input string name);
    int start;
    int n;
    start = mon_ack[i][j];
    n = 0;
    while (mon_ack[i][j] == start && n < limit) begin
      tick();
      n++;
    end
    n_assert++;
    if (mon_ack[i][j] == start) begin
      n_fail++;
      $display("[TB] FAIL %s: acks seen 0 within %0d cycles, expected 1", name, limit);
    end
  endtask

  function automatic bit expAck(input int i, input int j);
    case (j)
      0:       return exp_o[i].acka;
      1:       return exp_o[i].ackb;
      default: return exp_o[i].ackad;
    endcase
  endfunction

  task automatic applyStimulus();
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 3; j++) begin
        if (expAck(i, j)) begin
          if ($urandom_range(0, 1) == 0) req_v[i][j] = 1'b0;
          else if (j < 2) code_v[i][j] = 10'($urandom);
        end else if (req_v[i][j]) begin
          if ($urandom_range(0, 63) == 0) req_v[i][j] = 1'b0;
        end else if ($urandom_range(0, 7) == 0) begin
          req_v[i][j] = 1'b1;
          if (j < 2) code_v[i][j] = 10'($urandom);
        end
      end
    end
  endtask

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int rel;
    int set_cyc;
    int g;
    int n;
    div_v[0] = D0;
    div_v[1] = D1;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req_v[i]     = '0;
      code_v[i][0] = '0;
      code_v[i][1] = '0;
      sdout_v[i]   = 1'b0;
      act[i]       = 1'b0;
      gcyc[i]      = 0;
      mdev[i]      = 0;
      mlast[i]     = 2;
      mdata[i]     = '0;
      use_word[i]  = 1'b0;
      next_word[i] = '0;
      prev_sck[i]  = 1'b0;
      clearMon(i);
    end

    // Reset and quiet idle
    repeat (3) tick();
    rst = 1'b0;
    clearMon(0);
    clearMon(1);
    repeat (20) tick();
    chk("idle_sck_rises_inst0", mon_rises[0], 0);
    chk("idle_sck_rises_inst1", mon_rises[1], 0);
    chk("idle_sel_low_inst0", mon_sel_low[0][0] + mon_sel_low[0][1] + mon_sel_low[0][2], 0);
    chk("idle_busy_pin", int'(if0.busy), 0);

    // Single DAC A frame, code 0x2A5
    clearMon(0);
    req_v[0][0]  = 1'b1;
    code_v[0][0] = 10'h2A5;
    set_cyc = cyc;
    waitAck(0, 0, 20, "dacA_ack");
    req_v[0][0] = 1'b0;
    repeat (300) tick();
    chk("dacA_ack_latency", ack_t[0][0] - set_cyc, 1);
    chk("dacA_ack_count", mon_ack[0][0], 1);
    chk("dacA_csld_low_cycles", mon_sel_low[0][0], 256);
    chk("dacA_sck_rises", mon_rises[0], 16);
    chk("dacA_sdin_bits", int'(mon_bits[0]), 16'hFA94);

    // ADC frame returning 0x3C1 behind a null bit
    clearMon(0);
    use_word[0]  = 1'b1;
    next_word[0] = 16'h7820;
    req_v[0][2]  = 1'b1;
    waitAck(0, 2, 20, "adc_ack");
    req_v[0][2] = 1'b0;
    repeat (300) tick();
    chk("adc_valid_count", mon_valid[0], 1);
    chk("adc_data", int'(mon_vdata[0]), 10'h3C1);
    chk("adc_cs_low_cycles", mon_sel_low[0][2], 256);
    chk("adc_other_selects_low", mon_sel_low[0][0] + mon_sel_low[0][1], 0);

    // All three requests held from reset
    rst = 1'b1;
    req_v[0]     = 3'b111;
    code_v[0][0] = 10'($urandom);
    code_v[0][1] = 10'($urandom);
    repeat (3) tick();
    rst = 1'b0;
    rel = cyc;
    clearMon(0);
    n = 0;
    while (ack_n[0] < 5 && n < 5 * 264 + 50) begin
      tick();
      n++;
    end
    req_v[0] = 3'b000;
    chk("rr_ack_count", ack_n[0], 5);
    chk("rr_first_ack_delay", ack_t[0][0] - rel, 1);
    chk("rr_order0", ack_d[0][0], 0);
    chk("rr_order1", ack_d[0][1], 1);
    chk("rr_order2", ack_d[0][2], 2);
    chk("rr_order3", ack_d[0][3], 0);
    chk("rr_order4", ack_d[0][4], 1);
    for (int k = 0; k < 4; k++) chk("rr_grant_spacing", ack_t[0][k + 1] - ack_t[0][k], 264);
    repeat (300) tick();
    chk("rr_dual_select_low", mon_dual[0], 0);

    // Reset at cycle 100 of a DAC B frame, request left pending
    clearMon(0);
    req_v[0][1]  = 1'b1;
    code_v[0][1] = 10'($urandom);
    waitAck(0, 1, 20, "dacB_ack");
    g = cyc;
    while (cyc < g + 99) tick();
    chk("dacB_csld_low_before_reset", int'(if0.CSLD_B), 0);
    rst = 1'b1;
    #1;
    chk("abort_csld_b_high", int'(if0.CSLD_B), 1);
    chk("abort_sck_low", int'(if0.SCK), 0);
    chk("abort_sdin_low", int'(if0.SDIN), 0);
    chk("abort_busy_low", int'(if0.busy), 0);
    chk("abort_ack_b_low", int'(if0.ack_b), 0);
    repeat (2) tick();
    rst = 1'b0;
    rel = cyc;
    clearMon(0);
    tick();
    chk("regrant_ack_b_count", mon_ack[0][1], 1);
    chk("regrant_ack_b_cycle", ack_t[0][0] - rel, 1);
    req_v[0][1] = 1'b0;
    repeat (300) tick();

    // CLK_DIV=2 back-to-back DAC A
    clearMon(1);
    req_v[1][0]  = 1'b1;
    code_v[1][0] = 10'($urandom);
    n = 0;
    while (ack_n[1] < 6 && n < 6 * 66 + 20) begin
      tick();
      n++;
    end
    req_v[1][0] = 1'b0;
    chk("div2_ack_count", ack_n[1], 6);
    for (int k = 0; k < 5; k++) chk("div2_period", ack_t[1][k + 1] - ack_t[1][k], 66);
    chk("div2_only_dac_a", mon_ack[1][1] + mon_ack[1][2], 0);
    repeat (80) tick();

    // Randomized traffic on both instances, with one mid-run reset
    clearMon(0);
    clearMon(1);
    for (int r = 0; r < 6000; r++) begin
      applyStimulus();
      if (r == 3000) rst = 1'b1;
      if (r == 3002) rst = 1'b0;
      tick();
    end
    chk("rand_dual_select_low_inst0", mon_dual[0], 0);
    chk("rand_dual_select_low_inst1", mon_dual[1], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
